// File: rtl/sha3_pkg.sv
// ----------------------------------------------------------------------------
// sha3_pkg
// Shared types and constants for the sha3 message packer and its bench.
//   state_t       : packer FSM states (COLLECT, EMIT, EMIT_LAST)
//   byte_num_t    : valid-byte count reported with the final word (0..3)
//   byte_cnt_t    : byte collection counter (0..4)
//   BYTES_PER_WORD: bytes packed per keccak input word
// ----------------------------------------------------------------------------
package sha3_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] byte_num_t;
    typedef logic [2:0] byte_cnt_t;

    localparam byte_cnt_t FULL_CNT = byte_cnt_t'(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        EMIT      = 2'd1,
        EMIT_LAST = 2'd2
    } state_t;

endpackage

// File: rtl/sha3_msg_packer_if.sv
// ----------------------------------------------------------------------------
// sha3_msg_packer_if
// Bundles the byte-stream side and the keccak word side of the packer.
//   s_data/s_valid/s_last/s_ready : byte stream with end-of-message marker
//   empty_req                     : request a zero-length message
//   in/in_ready/byte_num/is_last  : word towards keccak
//   buffer_full                   : keccak back-pressure
// Modports:
//   slave  : the packer
//   master : the environment (byte source plus keccak core)
// ----------------------------------------------------------------------------
interface sha3_msg_packer_if #(
    parameter int WORD_W = 32
);
    import sha3_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              empty_req;
    logic [WORD_W-1:0] in;
    logic              in_ready;
    byte_num_t         byte_num;
    logic              is_last;
    logic              buffer_full;

    modport slave (
        input  s_data, s_valid, s_last, empty_req, buffer_full,
        output s_ready, in, in_ready, byte_num, is_last
    );

    modport master (
        output s_data, s_valid, s_last, empty_req, buffer_full,
        input  s_ready, in, in_ready, byte_num, is_last
    );

endinterface

// File: rtl/sha3_byte_shifter.sv
// ----------------------------------------------------------------------------
// sha3_byte_shifter
// Holds the byte shift register and the 0..4 byte counter. Presents, for the
// byte currently offered, the count and the zero-padded word that would result
// if that byte were accepted, so the FSM can load it in the same cycle.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   i_shift       : shift i_data in this cycle
//   i_data        : byte to shift in
//   i_clear       : clear register and counter (word consumed)
//   o_count       : bytes currently held
//   o_next_count  : count after accepting i_data
//   o_next_word   : word after accepting i_data, first byte in [31:24],
//                   unused low bytes zero
// ----------------------------------------------------------------------------
module sha3_byte_shifter
    import sha3_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_shift,
    input  logic [7:0]  i_data,
    input  logic        i_clear,
    output byte_cnt_t   o_count,
    output byte_cnt_t   o_next_count,
    output logic [31:0] o_next_word
);

    logic [31:0] r_sr;
    byte_cnt_t   r_count;
    logic [31:0] w_sr_next;
    byte_cnt_t   w_next_count;
    logic [31:0] w_padded;

    // Bytes enter at the low end; left-justifying by the count puts the first
    // byte of the message in [31:24] and drops anything older.
    assign w_sr_next    = {r_sr[23:0], i_data};
    assign w_next_count = r_count + byte_cnt_t'(1);

    always_comb begin
        w_padded = w_sr_next;
        case (w_next_count)
            3'd1:    w_padded = {w_sr_next[7:0], 24'd0};
            3'd2:    w_padded = {w_sr_next[15:0], 16'd0};
            3'd3:    w_padded = {w_sr_next[23:0], 8'd0};
            default: w_padded = w_sr_next;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_sr    <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_sr    <= w_sr_next;
            r_count <= w_next_count;
        end
    end

    assign o_count      = r_count;
    assign o_next_count = w_next_count;
    assign o_next_word  = w_padded;

endmodule

// File: rtl/sha3_msg_packer.sv
// ----------------------------------------------------------------------------
// sha3_msg_packer
// Packs a byte stream into 32-bit words for the keccak core and generates the
// end-of-message encoding (is_last/byte_num), including the extra empty final
// word when the message length is a multiple of 4. One word is in flight at a
// time; no byte is accepted while a word is pending.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   bus          : sha3_msg_packer_if.slave (byte stream + keccak word side)
//   msg_count    : messages fully handed to keccak, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module sha3_msg_packer
    import sha3_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    sha3_msg_packer_if.slave  bus,
    output logic [CNT_W-1:0]  msg_count
);

    state_t            r_state;
    logic [WORD_W-1:0] r_in;
    logic              r_in_ready;
    byte_num_t         r_byte_num;
    logic              r_is_last;
    logic              r_s_ready;
    logic              r_pending_empty;
    logic [CNT_W-1:0]  r_msg_count;

    logic              w_accept;
    logic              w_consume;
    byte_cnt_t         w_count;
    byte_cnt_t         w_next_count;
    logic [31:0]       w_word;

    assign w_accept  = bus.s_valid && r_s_ready;
    assign w_consume = r_in_ready && !bus.buffer_full;

    sha3_byte_shifter u_shifter (
        .clock        (clock),
        .reset        (reset),
        .i_shift      (w_accept),
        .i_data       (bus.s_data),
        .i_clear      (w_consume),
        .o_count      (w_count),
        .o_next_count (w_next_count),
        .o_next_word  (w_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= COLLECT;
            r_in            <= '0;
            r_in_ready      <= 1'b0;
            r_byte_num      <= '0;
            r_is_last       <= 1'b0;
            r_s_ready       <= 1'b1;
            r_pending_empty <= 1'b0;
            r_msg_count     <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (bus.s_last) begin
                            r_in       <= w_word;
                            r_in_ready <= 1'b1;
                            r_s_ready  <= 1'b0;
                            if (w_next_count == FULL_CNT) begin
                                // Full last word: keccak still needs an empty
                                // final word to mark the end of the message.
                                r_is_last       <= 1'b0;
                                r_byte_num      <= '0;
                                r_pending_empty <= 1'b1;
                                r_state         <= EMIT;
                            end else begin
                                r_is_last  <= 1'b1;
                                r_byte_num <= w_next_count[1:0];
                                r_state    <= EMIT_LAST;
                            end
                        end else if (w_next_count == FULL_CNT) begin
                            r_in       <= w_word;
                            r_in_ready <= 1'b1;
                            r_s_ready  <= 1'b0;
                            r_is_last  <= 1'b0;
                            r_byte_num <= '0;
                            r_state    <= EMIT;
                        end
                    end else if (bus.empty_req && w_count == '0) begin
                        r_in       <= '0;
                        r_in_ready <= 1'b1;
                        r_s_ready  <= 1'b0;
                        r_is_last  <= 1'b1;
                        r_byte_num <= '0;
                        r_state    <= EMIT_LAST;
                    end
                end

                EMIT: begin
                    if (w_consume) begin
                        if (r_pending_empty) begin
                            r_in            <= '0;
                            r_is_last       <= 1'b1;
                            r_byte_num      <= '0;
                            r_pending_empty <= 1'b0;
                            r_state         <= EMIT_LAST;
                        end else begin
                            r_in_ready <= 1'b0;
                            r_s_ready  <= 1'b1;
                            r_state    <= COLLECT;
                        end
                    end
                end

                EMIT_LAST: begin
                    if (w_consume) begin
                        r_msg_count <= r_msg_count + CNT_W'(1);
                        r_in_ready  <= 1'b0;
                        r_is_last   <= 1'b0;
                        r_byte_num  <= '0;
                        r_s_ready   <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end

                default: begin
                    r_state         <= COLLECT;
                    r_in_ready      <= 1'b0;
                    r_is_last       <= 1'b0;
                    r_byte_num      <= '0;
                    r_s_ready       <= 1'b1;
                    r_pending_empty <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in       = r_in;
    assign bus.in_ready = r_in_ready;
    assign bus.byte_num = r_byte_num;
    assign bus.is_last  = r_is_last;
    assign bus.s_ready  = r_s_ready;
    assign msg_count    = r_msg_count;

endmodule

// File: tb/tb_sha3_msg_packer.sv
// ----------------------------------------------------------------------------
// tb_sha3_msg_packer
// Directed bench for sha3_msg_packer (CNT_W=4 so the counter wrap is reachable).
// ----------------------------------------------------------------------------
module tb_sha3_msg_packer;
    import sha3_pkg::*;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CNT_W-1:0] msg_count;
    int               n_checks = 0;
    int               n_fail   = 0;
    int               exp_msg  = 0;

    sha3_msg_packer_if #(.WORD_W(32)) bus();

    sha3_msg_packer #(
        .WORD_W (32),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .msg_count (msg_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer a byte from a falling edge, hold it until s_ready, return 1 ns
    // after the edge that accepted it.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited;
        waited = 0;
        @(negedge clock);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        chk("s_ready_wait", 32'(bus.s_ready), 32'd1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
    endtask

    task automatic check_word(input string tag, input logic [31:0] exp_in,
                              input logic exp_last, input logic [1:0] exp_bn);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_in"},       bus.in,            exp_in);
        chk({tag, "_is_last"},  32'(bus.is_last),  32'(exp_last));
        chk({tag, "_byte_num"}, 32'(bus.byte_num), 32'(exp_bn));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_is_last"},  32'(bus.is_last),  32'd0);
        chk({tag, "_byte_num"}, 32'(bus.byte_num), 32'd0);
        chk({tag, "_s_ready"},  32'(bus.s_ready),  32'd1);
        chk({tag, "_msg_count"}, 32'(msg_count), 32'(exp_msg % (1 << CNT_W)));
    endtask

    initial begin
        bus.s_data      = 8'h00;
        bus.s_valid     = 1'b0;
        bus.s_last      = 1'b0;
        bus.empty_req   = 1'b0;
        bus.buffer_full = 1'b0;

        // Reset state
        #12;
        check_idle("reset");
        chk("reset_in", bus.in, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // "abc": one partial last word, in_ready high for one cycle
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        check_word("abc", 32'h61626300, 1'b1, 2'd3);
        chk("abc_s_ready_busy", 32'(bus.s_ready), 32'd0);
        chk("abc_msg_before", 32'(msg_count), 32'd0);
        step();
        exp_msg++;
        check_idle("abc_done");

        // Exactly 4 bytes: full word, then extra empty last word
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        check_word("four_w0", 32'h01020304, 1'b0, 2'd0);
        step();
        check_word("four_w1", 32'h00000000, 1'b1, 2'd0);
        step();
        exp_msg++;
        check_idle("four_done");

        // 9 bytes with a 5-cycle stall on the second word
        send_byte(8'h10, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        check_word("nine_w0", 32'h10111213, 1'b0, 2'd0);
        step();
        chk("nine_w0_consumed", 32'(bus.in_ready), 32'd0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h17, 1'b0);
        check_word("nine_w1", 32'h14151617, 1'b0, 2'd0);
        bus.buffer_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_in", bus.in, 32'h14151617);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd1);
            chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        end
        bus.buffer_full = 1'b0;
        step();
        chk("nine_w1_consumed", 32'(bus.in_ready), 32'd0);
        send_byte(8'h18, 1'b1);
        check_word("nine_w2", 32'h18000000, 1'b1, 2'd1);
        step();
        exp_msg++;
        check_idle("nine_done");

        // empty_req while idle
        @(negedge clock);
        bus.empty_req = 1'b1;
        step();
        bus.empty_req = 1'b0;
        check_word("empty", 32'h00000000, 1'b1, 2'd0);
        step();
        exp_msg++;
        check_idle("empty_done");

        // empty_req together with a byte: the byte wins
        bus.empty_req = 1'b1;
        send_byte(8'h55, 1'b1);
        bus.empty_req = 1'b0;
        check_word("empty_byte", 32'h55000000, 1'b1, 2'd1);
        step();
        exp_msg++;
        check_idle("empty_byte_done");

        // Reset mid-message discards the partial bytes
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        exp_msg = 0;
        check_idle("midreset");
        chk("midreset_in", bus.in, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'hAA, 1'b1);
        check_word("after_reset", 32'hAA000000, 1'b1, 2'd1);
        step();
        exp_msg++;
        check_idle("after_reset_done");

        // Counter wrap: 17 one-byte messages from zero leave msg_count at 1
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_msg = 0;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i + 1), 1'b1);
            step();
            exp_msg++;
            chk("wrap_msg_count", 32'(msg_count), 32'(exp_msg % (1 << CNT_W)));
        end
        chk("wrap_final", 32'(msg_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
